// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the sample-RAM port arbiter: FSM states,
// requester identifiers and the RAM geometry.
package ram_arb_pkg;

    localparam int RAM_AW = 5;
    localparam int RAM_DW = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RDW  = 3'd3,
        RACK = 3'd4
    } state_t;

    typedef enum logic {
        GNT_I2C = 1'b0,
        GNT_LD  = 1'b1
    } gnt_t;

    // The loader can only write, so only an I2C grant can turn into a read.
    function automatic logic grant_is_write(input gnt_t id, input logic we_i2c);
        return (id == GNT_LD) || we_i2c;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester handshakes and the RAM port seen by the arbiter.
interface ram_port_arbiter_if #(
    parameter int AW = ram_arb_pkg::RAM_AW,
    parameter int DW = ram_arb_pkg::RAM_DW
) ();

    logic          req_i2c;
    logic          we_i2c;
    logic [AW-1:0] addr_i2c;
    logic [DW-1:0] wdata_i2c;
    logic          ack_i2c;

    logic          req_ld;
    logic [AW-1:0] addr_ld;
    logic [DW-1:0] wdata_ld;
    logic          ack_ld;

    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          busy;

    modport slave (
        input  req_i2c, we_i2c, addr_i2c, wdata_i2c,
        input  req_ld, addr_ld, wdata_ld,
        input  ram_dout,
        output ack_i2c, ack_ld, rdata,
        output ram_addr, ram_din, ram_we, busy
    );

    modport master (
        output req_i2c, we_i2c, addr_i2c, wdata_i2c,
        output req_ld, addr_ld, wdata_ld,
        output ram_dout,
        input  ack_i2c, ack_ld, rdata,
        input  ram_addr, ram_din, ram_we, busy
    );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner select between the I2C slave and the RAM loader.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter bit I2C_PRIORITY = 1'b0
) (
    input  logic i_req_i2c,
    input  logic i_req_ld,
    input  gnt_t i_last_gnt,
    output logic o_grant_valid,
    output gnt_t o_grant_id
);

    // Single requests win outright; a tie goes to I2C or to whoever was not served last.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = GNT_I2C;
        case ({i_req_i2c, i_req_ld})
            2'b10: begin
                o_grant_valid = 1'b1;
                o_grant_id    = GNT_I2C;
            end
            2'b01: begin
                o_grant_valid = 1'b1;
                o_grant_id    = GNT_LD;
            end
            2'b11: begin
                o_grant_valid = 1'b1;
                if (I2C_PRIORITY) begin
                    o_grant_id = GNT_I2C;
                end else if (i_last_gnt == GNT_LD) begin
                    o_grant_id = GNT_I2C;
                end else begin
                    o_grant_id = GNT_LD;
                end
            end
            default: begin
                o_grant_valid = 1'b0;
                o_grant_id    = GNT_I2C;
            end
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous 32x8 RAM port between the I2C slave (read/write) and
// the switch-driven loader (write only); every RAM-side and ack output is registered.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW           = RAM_AW,
    parameter int DW           = RAM_DW,
    parameter bit I2C_PRIORITY = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);

    state_t        r_state;
    state_t        w_next_state;
    gnt_t          r_last_gnt;
    gnt_t          w_last_gnt_nxt;
    gnt_t          w_gnt_id;
    logic          w_gnt_valid;

    logic [AW-1:0] r_ram_addr;
    logic [AW-1:0] w_ram_addr_nxt;
    logic [DW-1:0] r_ram_din;
    logic [DW-1:0] w_ram_din_nxt;
    logic          r_ram_we;
    logic          w_ram_we_nxt;
    logic          r_ack_i2c;
    logic          w_ack_i2c_nxt;
    logic          r_ack_ld;
    logic          w_ack_ld_nxt;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] w_rdata_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    ram_arb_pick #(
        .I2C_PRIORITY (I2C_PRIORITY)
    ) u_pick (
        .i_req_i2c     (bus.req_i2c),
        .i_req_ld      (bus.req_ld),
        .i_last_gnt    (r_last_gnt),
        .o_grant_valid (w_gnt_valid),
        .o_grant_id    (w_gnt_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and next values of every registered output. Acks and ram_we
    // are computed one state early so they appear in the WR / RACK cycles.
    always_comb begin
        w_next_state   = r_state;
        w_last_gnt_nxt = r_last_gnt;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_din_nxt  = r_ram_din;
        w_ram_we_nxt   = 1'b0;
        w_ack_i2c_nxt  = 1'b0;
        w_ack_ld_nxt   = 1'b0;
        w_rdata_nxt    = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_last_gnt_nxt = w_gnt_id;
                    if (w_gnt_id == GNT_I2C) begin
                        w_ram_addr_nxt = bus.addr_i2c;
                        w_ram_din_nxt  = bus.wdata_i2c;
                    end else begin
                        w_ram_addr_nxt = bus.addr_ld;
                        w_ram_din_nxt  = bus.wdata_ld;
                    end
                    if (grant_is_write(w_gnt_id, bus.we_i2c)) begin
                        w_next_state  = WR;
                        w_ram_we_nxt  = 1'b1;
                        w_ack_i2c_nxt = (w_gnt_id == GNT_I2C);
                        w_ack_ld_nxt  = (w_gnt_id == GNT_LD);
                    end else begin
                        w_next_state = RD;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            WR: begin
                w_next_state = IDLE;
            end
            RD: begin
                w_next_state = RDW;
            end
            // ram_dout is valid here, one cycle after the address was presented.
            RDW: begin
                w_next_state  = RACK;
                w_rdata_nxt   = bus.ram_dout;
                w_ack_i2c_nxt = 1'b1;
            end
            RACK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        w_busy_nxt = (w_next_state != IDLE);
    end

    // Output and datapath registers; a pending read is simply abandoned on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt <= GNT_LD;
            r_ram_addr <= {AW{1'b0}};
            r_ram_din  <= {DW{1'b0}};
            r_ram_we   <= 1'b0;
            r_ack_i2c  <= 1'b0;
            r_ack_ld   <= 1'b0;
            r_rdata    <= {DW{1'b0}};
            r_busy     <= 1'b0;
        end else begin
            r_last_gnt <= w_last_gnt_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_din  <= w_ram_din_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ack_i2c  <= w_ack_i2c_nxt;
            r_ack_ld   <= w_ack_ld_nxt;
            r_rdata    <= w_rdata_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_din  = r_ram_din;
    assign bus.ram_we   = r_ram_we;
    assign bus.ack_i2c  = r_ack_i2c;
    assign bus.ack_ld   = r_ack_ld;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;

endmodule
